// File: rtl/rx_slot_manager_pkg.sv
// Shared types and address helpers for the RX slot manager.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rx_slot_pkg;

    // Slot hand-off sequence: wait for room, arm a slot, fill it, publish it.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        BUSY   = 2'd2,
        COMMIT = 2'd3
    } rx_state_e;

    // Width of a slot index. A one-bit floor keeps degenerate sizes legal.
    function automatic int slot_ptr_w(input int num_slots);
        return (num_slots > 1) ? $clog2(num_slots) : 1;
    endfunction

    // Byte address of slot idx. All arithmetic wraps at 2^32 like the bus does.
    function automatic logic [31:0] slot_base(input logic [31:0] base_addr,
                                              input logic [31:0] slot_bytes,
                                              input logic [31:0] idx);
        return base_addr + (idx * slot_bytes);
    endfunction

endpackage

// File: rtl/rx_slot_manager_if.sv
// Bundles the write-engine snoop, slot-offset hand-off and CPU ring view.
// Latency: wires only, no storage.
// Backpressure: wb_addr_ready low holds the write engine; the CPU drains via cpu_release_i.
interface rx_slot_manager_if #(
    parameter int NUM_SLOTS = 4
) ();
    localparam int CW = rx_slot_pkg::slot_ptr_w(NUM_SLOTS) + 1;

    // Write-engine bus as observed by the manager.
    logic          snp_cyc_i;
    logic          snp_stb_i;
    logic          snp_ack_i;

    // Slot offset handed to the write engine.
    logic [31:0]   wb_addr_offset;
    logic          wb_addr_ready;

    // CPU view of the filled-slot ring.
    logic [CW-1:0] cpu_pending;
    logic [31:0]   cpu_slot_addr;
    logic [15:0]   cpu_slot_len;
    logic          cpu_release_i;
    logic          irq_o;
    logic          overrun_o;

    // Traffic statistics.
    logic [31:0]   stat_pkt_count;
    logic [31:0]   stat_byte_count;

    // Manager side.
    modport slave (
        input  snp_cyc_i, snp_stb_i, snp_ack_i, cpu_release_i,
        output wb_addr_offset, wb_addr_ready,
        output cpu_pending, cpu_slot_addr, cpu_slot_len, irq_o, overrun_o,
        output stat_pkt_count, stat_byte_count
    );

    // Engine/CPU side.
    modport master (
        output snp_cyc_i, snp_stb_i, snp_ack_i, cpu_release_i,
        input  wb_addr_offset, wb_addr_ready,
        input  cpu_pending, cpu_slot_addr, cpu_slot_len, irq_o, overrun_o,
        input  stat_pkt_count, stat_byte_count
    );

endinterface

// File: rtl/rx_slot_manager_len_ram.sv
// Per-slot packet length store: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after i_we; read is combinational.
// Backpressure: none, always accepts writes.
module rx_slot_len_ram #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [15:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [15:0]   o_rdata
);
    // Contents need no reset: a slot is only read after it has been committed.
    logic [15:0] r_mem [DEPTH];

    // Record the length of the slot being committed.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/rx_slot_manager.sv
// Arms DMA slots for the RX write engine, snoops its bus to size packets, rings them to the CPU.
// Latency: cyc fall -> irq/cpu_pending 2 cycles; commit -> next wb_addr_ready 2 cycles.
// Backpressure: with all slots pending wb_addr_ready stays low; RXSM_STATS_EN adds packet/byte counters.
module rx_slot_manager
    import rx_slot_pkg::*;
#(
    parameter int          NUM_SLOTS  = 4,
    parameter int          SLOT_BYTES = 2048,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    rx_slot_manager_if.slave   bus
);
    localparam int            PW       = slot_ptr_w(NUM_SLOTS);
    localparam int            CW       = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_FULL = CW'(NUM_SLOTS);
    localparam logic [31:0]   SLOT_SZ  = 32'(SLOT_BYTES);

    rx_state_e     r_state;
    rx_state_e     w_state_nxt;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_pending;
    logic [31:0]   r_total_bytes;
    logic [31:0]   r_pkt_bytes;
    logic [31:0]   r_offset;
    logic          r_cyc_prev;
    logic          r_overrun;

    logic          w_ack;
    logic          w_cyc_rise;
    logic          w_cyc_fall;
    logic          w_arm_entry;
    logic          w_start;
    logic          w_commit;
    logic          w_release;
    logic          w_ready;
    logic [31:0]   w_ack_bytes;
    logic [31:0]   w_total_nxt;
    logic [15:0]   w_len_sat;
    logic [15:0]   w_rd_len;

    // A completed word transfer on the engine's bus, whatever state we are in.
    assign w_ack       = bus.snp_cyc_i & bus.snp_stb_i & bus.snp_ack_i;
    assign w_ack_bytes = w_ack ? 32'd4 : 32'd0;
    assign w_total_nxt = r_total_bytes + w_ack_bytes;
    assign w_cyc_rise  = bus.snp_cyc_i & ~r_cyc_prev;
    assign w_cyc_fall  = ~bus.snp_cyc_i & r_cyc_prev;
    assign w_release   = bus.cpu_release_i & (r_pending != CNT_ZERO);

    // Lengths beyond 16 bits clamp; the overrun flag already marks such packets.
    assign w_len_sat   = (|r_pkt_bytes[31:16]) ? 16'hFFFF : r_pkt_bytes[15:0];

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-state strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_arm_entry = 1'b0;
        w_start     = 1'b0;
        w_commit    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_pending < CNT_FULL) begin
                    w_arm_entry = 1'b1;
                    w_state_nxt = ARM;
                end
            end
            ARM: begin
                w_ready = 1'b1;
                if (w_cyc_rise) begin
                    w_start     = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (w_cyc_fall) begin
                    w_state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Byte tracking, offset latch, ring pointers and pending count.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cyc_prev    <= 1'b0;
            r_total_bytes <= '0;
            r_pkt_bytes   <= '0;
            r_offset      <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_pending     <= '0;
            r_overrun     <= 1'b0;
        end else begin
            r_cyc_prev    <= bus.snp_cyc_i;
            r_total_bytes <= w_total_nxt;

            // The engine adds its running byte count to the offset, so subtract
            // the count as it will stand once this edge has landed.
            if (w_arm_entry) begin
                r_offset <= slot_base(BASE_ADDR, SLOT_SZ, 32'(r_wr_ptr)) - w_total_nxt;
            end

            // A zero-wait slave may ack in the very first cycle of the packet.
            if (w_start) begin
                r_pkt_bytes <= w_ack_bytes;
            end else if (r_state == BUSY) begin
                r_pkt_bytes <= r_pkt_bytes + w_ack_bytes;
            end

            if (w_commit) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (r_pkt_bytes > SLOT_SZ) begin
                    r_overrun <= 1'b1;
                end
            end

            if (w_release) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end

            // Commit and release in the same cycle cancel out.
            if (w_commit && !w_release) begin
                r_pending <= r_pending + CNT_ONE;
            end else if (!w_commit && w_release) begin
                r_pending <= r_pending - CNT_ONE;
            end
        end
    end

    rx_slot_len_ram #(
        .DEPTH (NUM_SLOTS),
        .AW    (PW)
    ) u_len_ram (
        .i_clk   (wb_clk_i),
        .i_we    (w_commit),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_len_sat),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_len)
    );

`ifdef RXSM_STATS_EN
    logic [31:0] r_stat_pkts;
    logic [31:0] r_stat_bytes;

    // Committed packet and byte totals, free-running and wrapping.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_stat_pkts  <= '0;
            r_stat_bytes <= '0;
        end else if (w_commit) begin
            r_stat_pkts  <= r_stat_pkts + 32'd1;
            r_stat_bytes <= r_stat_bytes + r_pkt_bytes;
        end
    end

    assign bus.stat_pkt_count  = r_stat_pkts;
    assign bus.stat_byte_count = r_stat_bytes;
`else
    assign bus.stat_pkt_count  = 32'd0;
    assign bus.stat_byte_count = 32'd0;
`endif

    assign bus.wb_addr_offset = r_offset;
    assign bus.wb_addr_ready  = w_ready;
    assign bus.cpu_pending    = r_pending;
    assign bus.cpu_slot_addr  = slot_base(BASE_ADDR, SLOT_SZ, 32'(r_rd_ptr));
    assign bus.cpu_slot_len   = w_rd_len;
    assign bus.irq_o          = (r_pending != CNT_ZERO);
    assign bus.overrun_o      = r_overrun;

endmodule

// File: tb/tb_rx_slot_manager.sv
// Randomized bench for rx_slot_manager against a queue-based ring model.
// Latency: model commits one edge after the cyc-fall edge.
// Backpressure: engine driver waits on wb_addr_ready with a cycle budget.
module tb_rx_slot_manager;
    localparam int          NS   = 4;
    localparam int          SB   = 2048;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic clk;
    logic rst;

    rx_slot_manager_if #(.NUM_SLOTS(NS)) bus ();

    rx_slot_manager #(
        .NUM_SLOTS  (NS),
        .SLOT_BYTES (SB),
        .BASE_ADDR  (BASE)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: filled-slot lengths in CPU order plus running totals.
    int unsigned q[$];
    int          wr_cnt, rd_cnt;
    logic [31:0] m_total, m_cur, m_seen_off;
    bit          m_in_pkt, m_commit_due, m_prev_cyc, m_overrun;
    logic [31:0] m_spkt, m_sbyte;
    bit          tb_stray;
    bit          rel_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sbase(input int idx);
        return BASE + 32'((idx % NS) * SB);
    endfunction

    function automatic logic [31:0] sat16(input int unsigned v);
        return (v > 65535) ? 32'hFFFF : 32'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    // One packet: wait for an armed slot, raise cyc, then nacks acked words.
    task automatic send_pkt(input int nacks, input bit rnd);
        int waited;
        waited = 0;
        while (!bus.wb_addr_ready && waited < 400) begin
            tick();
            waited++;
        end
        if (!bus.wb_addr_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got 0 expected 1 at %0t", $time);
            return;
        end
        bus.snp_cyc_i = 1'b1;
        bus.snp_stb_i = 1'b1;
        bus.snp_ack_i = 1'b0;
        tick();
        for (int i = 0; i < nacks; i++) begin
            if (rnd && $urandom_range(0, 2) == 0) begin
                bus.snp_stb_i = 1'b0;
                bus.snp_ack_i = 1'($urandom_range(0, 1));
                tick();
            end
            bus.snp_stb_i = 1'b1;
            bus.snp_ack_i = 1'b1;
            tick();
        end
        bus.snp_ack_i = 1'b0;
        bus.snp_stb_i = 1'b0;
        bus.snp_cyc_i = 1'b0;
        tick();
    endtask

    task automatic release_once();
        bus.cpu_release_i = 1'b1;
        tick();
        bus.cpu_release_i = 1'b0;
    endtask

    // Model update on every edge, then compare shortly after it.
    initial begin : model
        logic s_cyc, s_stb, s_ack, s_rel, s_rst, s_stray;
        bit   rel_ok;
        forever begin
            @(posedge clk);
            s_cyc   = bus.snp_cyc_i;
            s_stb   = bus.snp_stb_i;
            s_ack   = bus.snp_ack_i;
            s_rel   = bus.cpu_release_i;
            s_rst   = rst;
            s_stray = tb_stray;
            if (s_rst) begin
                q.delete();
                wr_cnt = 0; rd_cnt = 0;
                m_total = '0; m_cur = '0;
                m_in_pkt = 0; m_commit_due = 0; m_prev_cyc = 0; m_overrun = 0;
                m_spkt = '0; m_sbyte = '0;
            end else begin
                rel_ok = s_rel && (q.size() > 0);
                if (rel_ok) begin
                    void'(q.pop_front());
                    rd_cnt++;
                end
                if (m_commit_due) begin
                    q.push_back(m_cur);
                    wr_cnt++;
                    if (m_cur > 32'(SB)) m_overrun = 1;
                    m_spkt  = m_spkt + 1;
                    m_sbyte = m_sbyte + m_cur;
                    m_commit_due = 0;
                end
                if (s_cyc && !m_prev_cyc && !s_stray) begin
                    m_in_pkt = 1;
                    m_cur    = '0;
                end
                if (s_cyc && s_stb && s_ack) begin
                    if (m_in_pkt) begin
                        // Engine address for this word must land inside the armed slot.
                        chk("ack_addr", m_seen_off + m_total, sbase(wr_cnt) + m_cur);
                        m_cur = m_cur + 4;
                    end
                    m_total = m_total + 4;
                end
                if (!s_cyc && m_prev_cyc && m_in_pkt) begin
                    m_in_pkt     = 0;
                    m_commit_due = 1;
                end
                m_prev_cyc = s_cyc;
            end
            #1;
            chk("pending", 32'(bus.cpu_pending), 32'(q.size()));
            chk("irq", 32'(bus.irq_o), 32'(q.size() != 0));
            chk("slot_addr", bus.cpu_slot_addr, sbase(rd_cnt));
            if (q.size() > 0) chk("slot_len", 32'(bus.cpu_slot_len), sat16(q[0]));
            chk("overrun", 32'(bus.overrun_o), 32'(m_overrun));
`ifdef RXSM_STATS_EN
            chk("stat_pkts", bus.stat_pkt_count, m_spkt);
            chk("stat_bytes", bus.stat_byte_count, m_sbyte);
`else
            chk("stat_pkts_off", bus.stat_pkt_count, 32'd0);
            chk("stat_bytes_off", bus.stat_byte_count, 32'd0);
`endif
            if (bus.wb_addr_ready) begin
                chk("ready_room", 32'(q.size() < NS), 32'd1);
                chk("ready_idle", 32'(m_in_pkt || m_commit_due), 32'd0);
                chk("ready_offset", bus.wb_addr_offset + m_total, sbase(wr_cnt));
            end
            m_seen_off = bus.wb_addr_offset;
        end
    end

    // Random CPU releases while enabled.
    initial begin : releaser
        forever begin
            @(posedge clk);
            #3;
            if (rel_en) bus.cpu_release_i = ($urandom_range(0, 5) == 0);
        end
    end

    initial begin : watchdog
        #400000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int w;
        rst = 1'b1;
        tb_stray = 0;
        rel_en = 0;
        bus.snp_cyc_i = 1'b0;
        bus.snp_stb_i = 1'b0;
        bus.snp_ack_i = 1'b0;
        bus.cpu_release_i = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state, then armed one cycle later at slot 0.
        chk("rst_ready", 32'(bus.wb_addr_ready), 32'd0);
        chk("rst_pending", 32'(bus.cpu_pending), 32'd0);
        chk("rst_offset", bus.wb_addr_offset, 32'h0);
        chk("rst_irq", 32'(bus.irq_o), 32'd0);
        tick();
        chk("arm_ready", 32'(bus.wb_addr_ready), 32'd1);
        chk("arm_offset", bus.wb_addr_offset, 32'h0);

        // Single 10-word packet.
        send_pkt(10, 0);
        chk("pkt1_pend_early", 32'(bus.cpu_pending), 32'd0);
        tick();
        chk("pkt1_pending", 32'(bus.cpu_pending), 32'd1);
        chk("pkt1_addr", bus.cpu_slot_addr, 32'h0);
        chk("pkt1_len", 32'(bus.cpu_slot_len), 32'd40);
        chk("pkt1_irq", 32'(bus.irq_o), 32'd1);
        chk("pkt1_ready_early", 32'(bus.wb_addr_ready), 32'd0);
        tick();
        chk("pkt1_ready", 32'(bus.wb_addr_ready), 32'd1);
        chk("pkt1_next_off", bus.wb_addr_offset, 32'h0000_07D8);

        // Fill the ring, then stray acks while full.
        send_pkt(4, 0);
        send_pkt(8, 0);
        send_pkt(12, 0);
        tick();
        chk("full_pending", 32'(bus.cpu_pending), 32'd4);
        for (int i = 0; i < 5; i++) begin
            chk("full_no_ready", 32'(bus.wb_addr_ready), 32'd0);
            tick();
        end
        tb_stray = 1;
        bus.snp_cyc_i = 1'b1; bus.snp_stb_i = 1'b1; bus.snp_ack_i = 1'b1;
        repeat (3) tick();
        bus.snp_cyc_i = 1'b0; bus.snp_stb_i = 1'b0; bus.snp_ack_i = 1'b0;
        tick();
        tb_stray = 0;
        chk("stray_no_ready", 32'(bus.wb_addr_ready), 32'd0);
        release_once();
        w = 0;
        while (!bus.wb_addr_ready && w < 2) begin
            tick();
            w++;
        end
        chk("rel_ready", 32'(bus.wb_addr_ready), 32'd1);
        chk("rel_offset", bus.wb_addr_offset, 32'hFFFF_FF6C);

        // Commit and release on the same edge with two pending.
        release_once();
        chk("sim_pre_addr", bus.cpu_slot_addr, 32'h1000);
        send_pkt(5, 0);
        bus.cpu_release_i = 1'b1;
        tick();
        bus.cpu_release_i = 1'b0;
        chk("sim_pending", 32'(bus.cpu_pending), 32'd2);
        chk("sim_addr", bus.cpu_slot_addr, 32'h1800);

        // Drain, release while empty, then an oversized packet.
        release_once();
        tick();
        release_once();
        tick();
        release_once();
        chk("empty_rel_pending", 32'(bus.cpu_pending), 32'd0);
        chk("empty_rel_addr", bus.cpu_slot_addr, 32'h0800);
        chk("pre_overrun", 32'(bus.overrun_o), 32'd0);
        send_pkt(513, 0);
        tick();
        chk("ovr_flag", 32'(bus.overrun_o), 32'd1);
        chk("ovr_len", 32'(bus.cpu_slot_len), 32'd2052);
        chk("ovr_addr", bus.cpu_slot_addr, 32'h0800);
`ifdef RXSM_STATS_EN
        chk("stats_pkts_lit", bus.stat_pkt_count, 32'd6);
        chk("stats_bytes_lit", bus.stat_byte_count, 32'd2208);
`endif

        // Random traffic against random CPU releases.
        rel_en = 1;
        for (int p = 0; p < 30; p++) begin
            send_pkt($urandom_range(1, 24), 1);
        end
        rel_en = 0;
        tick();
        bus.cpu_release_i = 1'b0;
        for (int k = 0; k < 20 && bus.cpu_pending != 0; k++) begin
            release_once();
            tick();
        end
        chk("drain", 32'(bus.cpu_pending), 32'd0);

        // Reset in the middle of a packet, engine reset alongside.
        send_pkt(0, 0);
        tick();
        tick();
        w = 0;
        while (!bus.wb_addr_ready && w < 10) begin
            tick();
            w++;
        end
        bus.snp_cyc_i = 1'b1; bus.snp_stb_i = 1'b1;
        tick();
        bus.snp_ack_i = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        bus.snp_cyc_i = 1'b0; bus.snp_stb_i = 1'b0; bus.snp_ack_i = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        chk("mid_rst_overrun", 32'(bus.overrun_o), 32'd0);
        chk("mid_rst_pending", 32'(bus.cpu_pending), 32'd0);
        tick();
        chk("mid_rst_ready", 32'(bus.wb_addr_ready), 32'd1);
        chk("mid_rst_offset", bus.wb_addr_offset, 32'h0);
        send_pkt(3, 0);
        tick();
        chk("post_rst_len", 32'(bus.cpu_slot_len), 32'd12);
        tick();
        chk("post_rst_off", bus.wb_addr_offset, 32'h0000_07F4);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
